mem_lsu: RTL and testbench

Load/store initiator for the main memory port. Accepts one load or store at a time from the pipeline's MEM stage over a valid/ready handshake, drives the memory's addr/d_in/acc_size/wren/en request, and waits on busy with a bounded timeout. For loads it captures d_out, then zero- or sign-extends it. Each request returns exactly one single-cycle response to the pipeline.

---
 rtl/mem_pkg.sv | 10 +
 rtl/mem_lsu_if.sv | 25 ++
 rtl/lsu_load_align.sv | 15 +
 rtl/mem_lsu.sv | 76 +++++++
 tb/tb_mem_lsu.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: access-size encodings, LSU state type and default busy timeout
package mem_pkg;
  typedef logic [1:0] acc_t;
  localparam acc_t ACC_BYTE = 2'b00;
  localparam acc_t ACC_HALF = 2'b01;
  localparam acc_t ACC_WORD = 2'b10;
  localparam acc_t ACC_RSVD = 2'b11;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} lsu_state_e;
  localparam int TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: pipeline request/response and memory-port signals of the LSU
interface mem_lsu_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int ACCESS_SIZE = 2
);
  logic req_valid, req_ready, req_wr, req_signed;
  logic [0:ACCESS_SIZE-1] req_size;
  logic [0:ADDRESS_SIZE-1] req_addr;
  logic [0:DATA_SIZE-1] req_wdata;
  logic resp_valid, resp_err;
  logic [0:DATA_SIZE-1] resp_rdata;
  logic [0:ADDRESS_SIZE-1] mem_addr;
  logic [0:DATA_SIZE-1] mem_d_in, mem_d_out;
  logic [0:ACCESS_SIZE-1] mem_acc_size;
  logic mem_wren, mem_en, mem_busy;
  modport slave (
    input req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, mem_d_out, mem_busy,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_d_in, mem_acc_size, mem_wren, mem_en
  );
  modport master (
    output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, mem_d_out, mem_busy,
    input req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_d_in, mem_acc_size, mem_wren, mem_en
  );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: zero/sign extension of a right-justified load datum by access size
module lsu_load_align import mem_pkg::*; #(
  parameter int DATA_SIZE = 32,
  parameter int ACCESS_SIZE = 2
) (
  input  logic [0:DATA_SIZE-1]   d,
  input  logic [0:ACCESS_SIZE-1] size,
  input  logic                   sgn,
  output logic [0:DATA_SIZE-1]   q
);
  localparam int B = DATA_SIZE - 8;
  localparam int H = DATA_SIZE - 16;
  assign q = size == ACC_BYTE ? {{B{sgn & d[B]}}, d[B:DATA_SIZE-1]} :
             size == ACC_HALF ? {{H{sgn & d[H]}}, d[H:DATA_SIZE-1]} : d;
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store initiator with busy timeout.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses without touching memory.
module mem_lsu import mem_pkg::*; #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int ACCESS_SIZE = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input logic clk,
  input logic rst_n,
  mem_lsu_if.slave bus
);
  lsu_state_e state, nxt;
  logic [0:ADDRESS_SIZE-1] addr_q;
  logic [0:DATA_SIZE-1] wdata_q, dout_q, ext;
  logic [0:ACCESS_SIZE-1] size_q;
  logic wr_q, sgn_q, err_q, accept, bad, hit;
  logic [7:0] cnt;
  assign bus.req_ready = rst_n && state == IDLE && !bus.mem_busy;
  assign accept = bus.req_valid && bus.req_ready;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bad = bus.req_size == ACC_RSVD ||
               (bus.req_size == ACC_HALF && bus.req_addr[ADDRESS_SIZE-1]) ||
               (bus.req_size == ACC_WORD && bus.req_addr[ADDRESS_SIZE-2 +: 2] != 2'b00);
`else
  assign bad = bus.req_size == ACC_RSVD;
`endif
  // cnt holds the busy cycles already seen, so this WAIT cycle is number cnt+1
  assign hit = 32'(cnt) + 1 == TIMEOUT_CYCLES;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? (bad ? RESP : LAUNCH) : IDLE;
      LAUNCH:  nxt = WAIT;
      WAIT:    nxt = (!bus.mem_busy || hit) ? RESP : WAIT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      dout_q <= '0;
      size_q <= '0;
      wr_q <= 1'b0;
      sgn_q <= 1'b0;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        size_q <= bus.req_size;
        wr_q <= bus.req_wr;
        sgn_q <= bus.req_signed;
        err_q <= bad;
      end
      if (state == WAIT && !bus.mem_busy) dout_q <= bus.mem_d_out;
      if (state == WAIT && bus.mem_busy && hit) err_q <= 1'b1;
      cnt <= state == WAIT && bus.mem_busy ? cnt + 8'd1 : '0;
    end
  end
  lsu_load_align #(.DATA_SIZE(DATA_SIZE), .ACCESS_SIZE(ACCESS_SIZE)) u_align (
    .d(dout_q), .size(size_q), .sgn(sgn_q), .q(ext)
  );
  assign bus.resp_valid = state == RESP;
  assign bus.resp_err = state == RESP && err_q;
  assign bus.resp_rdata = state == RESP && !err_q && !wr_q ? ext : '0;
  assign bus.mem_en = state == LAUNCH;
  assign bus.mem_addr = addr_q;
  assign bus.mem_d_in = wdata_q;
  assign bus.mem_acc_size = size_q;
  assign bus.mem_wren = wr_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized and directed checks of mem_lsu against a per-cycle expectation model
module tb_mem_lsu;
  import mem_pkg::*;
  localparam int T = 4;
  localparam int N = 4096;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  mem_lsu_if bus();
  mem_lsu #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int compared = 0, mismatched = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  bit blocked[N], en_exp[N], rv_exp[N];
  logic err_exp[N];
  logic [31:0] rd_exp[N];
  logic [31:0] ex_addr, ex_din;
  logic [1:0] ex_size;
  logic ex_wr, exp_ready;
  int mem_n = 0, mem_left = 0;
  logic [31:0] mem_dout = 0;
  int last_resp = -1, en_count = 0;
  logic [31:0] last_rdata = 0, last_addr = 0, last_din = 0;
  logic last_err = 0, last_wr = 0;
  logic [1:0] last_size = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [1:0] sz, input bit sg, input logic [31:0] d);
    logic [31:0] b = {24'b0, d[7:0]};
    logic [31:0] h = {16'b0, d[15:0]};
    if (sz == 0) return (sg && d[7]) ? (b | 32'hFFFFFF00) : b;
    if (sz == 1) return (sg && d[15]) ? (h | 32'hFFFF0000) : h;
    return d;
  endfunction

  // memory: busy for mem_n sampled cycles after the en pulse, data valid only once busy drops
  initial begin
    bus.mem_busy = 0;
    bus.mem_d_out = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_left = 0;
        bus.mem_busy = 0;
      end else if (bus.mem_en) begin
        mem_left = mem_n + 1;
        bus.mem_busy = mem_n > 0;
        bus.mem_d_out = mem_n > 0 ? $urandom : mem_dout;
      end else if (mem_left > 0) begin
        mem_left--;
        if (mem_left == 0) begin
          bus.mem_busy = 0;
          bus.mem_d_out = mem_dout;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (cyc < N) begin
        exp_ready = rst_n && !blocked[cyc] && !bus.mem_busy;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        chk("resp_valid", 32'(bus.resp_valid), 32'(rv_exp[cyc]));
        chk("mem_en", 32'(bus.mem_en), 32'(en_exp[cyc]));
        if (rv_exp[cyc]) begin
          chk("resp_err", 32'(bus.resp_err), 32'(err_exp[cyc]));
          chk("resp_rdata", bus.resp_rdata, rd_exp[cyc]);
        end
        if (en_exp[cyc]) begin
          chk("mem_addr", bus.mem_addr, ex_addr);
          chk("mem_d_in", bus.mem_d_in, ex_din);
          chk("mem_acc_size", 32'(bus.mem_acc_size), 32'(ex_size));
          chk("mem_wren", 32'(bus.mem_wren), 32'(ex_wr));
        end
        if (!rst_n) begin
          chk("rst_mem_addr", bus.mem_addr, 0);
          chk("rst_mem_d_in", bus.mem_d_in, 0);
          chk("rst_mem_acc_size", 32'(bus.mem_acc_size), 0);
          chk("rst_mem_wren", 32'(bus.mem_wren), 0);
          chk("rst_resp_rdata", bus.resp_rdata, 0);
          chk("rst_resp_err", 32'(bus.resp_err), 0);
        end
        if (bus.resp_valid) begin
          last_resp = cyc;
          last_rdata = bus.resp_rdata;
          last_err = bus.resp_err;
        end
        if (bus.mem_en) begin
          en_count++;
          last_addr = bus.mem_addr;
          last_din = bus.mem_d_in;
          last_size = bus.mem_acc_size;
          last_wr = bus.mem_wren;
        end
      end
    end
  end

  task automatic do_txn(input bit wr, input bit [1:0] sz, input bit sg, input logic [31:0] ad,
                        input logic [31:0] wd, input logic [31:0] dout, input int n, input bit abort,
                        output int a);
    bit bad, got;
    int lat;
    @(negedge clk);
    bus.req_wr = wr;
    bus.req_size = sz;
    bus.req_signed = sg;
    bus.req_addr = ad;
    bus.req_wdata = wd;
    bus.req_valid = 1;
    mem_n = n;
    mem_dout = dout;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      #1;
      if (bus.req_ready) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      chk("accept_wait", 32'(got), 1);
      bus.req_valid = 0;
      a = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    a = cyc;
    bus.req_valid = 0;
    bad = sz == 2'b11;
`ifdef LSU_MISALIGN_TRAP_EN
    bad = bad || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00);
`endif
    lat = bad ? 1 : (n >= T ? T + 2 : 3 + n);
    for (int k = 0; k < lat; k++) blocked[a + k] = 1;
    en_exp[a] = !bad;
    rv_exp[a + lat - 1] = 1;
    err_exp[a + lat - 1] = bad || n >= T;
    rd_exp[a + lat - 1] = (bad || n >= T || wr) ? 32'h0 : ext(sz, sg, dout);
    ex_addr = ad;
    ex_din = wd;
    ex_size = sz;
    ex_wr = wr;
    if (abort) begin
      @(negedge clk);
      for (int k = 1; k <= lat; k++) begin
        blocked[a + k] = 0;
        rv_exp[a + k] = 0;
      end
      rst_n = 0;
      return;
    end
    while (cyc < a + lat) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000ns");
    $fatal(1);
  end

  initial begin
    int a, e0, r;
    bus.req_valid = 0;
    bus.req_wr = 0;
    bus.req_size = '0;
    bus.req_signed = 0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_req_ready", 32'(bus.req_ready), 0);
    chk("reset_resp_valid", 32'(bus.resp_valid), 0);
    chk("reset_mem_en", 32'(bus.mem_en), 0);
    rst_n = 1;
    #1;
    chk("ready_after_release", 32'(bus.req_ready), 1);

    do_txn(0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 2, 0, a);
    chk("word_load_latency", 32'(last_resp - a), 4);
    chk("word_load_rdata", last_rdata, 32'hDEADBEEF);
    chk("word_load_err", 32'(last_err), 0);

    do_txn(0, 2'b00, 1, 32'h13, 0, 32'h00000080, 0, 0, a);
    chk("sbyte_latency", 32'(last_resp - a), 2);
    chk("sbyte_rdata", last_rdata, 32'hFFFFFF80);
    do_txn(0, 2'b00, 0, 32'h13, 0, 32'h00000080, 0, 0, a);
    chk("ubyte_rdata", last_rdata, 32'h00000080);
    do_txn(0, 2'b01, 1, 32'h22, 0, 32'h12348001, 1, 0, a);
    chk("shalf_rdata", last_rdata, 32'hFFFF8001);

    e0 = en_count;
    do_txn(1, 2'b01, 0, 32'h202, 32'h00001234, 32'hFFFFFFFF, 1, 0, a);
    chk("store_en_pulses", 32'(en_count - e0), 1);
    chk("store_addr", last_addr, 32'h202);
    chk("store_d_in", last_din, 32'h00001234);
    chk("store_size", 32'(last_size), 1);
    chk("store_wren", 32'(last_wr), 1);
    chk("store_rdata", last_rdata, 0);
    chk("store_err", 32'(last_err), 0);

    do_txn(0, 2'b10, 0, 32'h300, 0, 32'h55, 9, 0, a);
    chk("timeout_latency", 32'(last_resp - a), 5);
    chk("timeout_err", 32'(last_err), 1);
    chk("timeout_rdata", last_rdata, 0);
    #3;
    chk("ready_low_while_busy", 32'(bus.req_ready), 0);

    e0 = en_count;
    do_txn(0, 2'b11, 0, 32'h400, 0, 32'h99, 0, 0, a);
    chk("rsvd_latency", 32'(last_resp - a), 0);
    chk("rsvd_err", 32'(last_err), 1);
    chk("rsvd_no_en", 32'(en_count - e0), 0);

    e0 = en_count;
    do_txn(0, 2'b10, 0, 32'h102, 0, 32'hCAFEF00D, 0, 0, a);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("misalign_latency", 32'(last_resp - a), 0);
    chk("misalign_err", 32'(last_err), 1);
    chk("misalign_no_en", 32'(en_count - e0), 0);
`else
    chk("misalign_en", 32'(en_count - e0), 1);
    chk("misalign_addr", last_addr, 32'h102);
    chk("misalign_rdata", last_rdata, 32'hCAFEF00D);
`endif

    r = last_resp;
    do_txn(0, 2'b10, 0, 32'h500, 0, 32'h77, 8, 1, a);
    #3;
    chk("abort_resp_valid", 32'(bus.resp_valid), 0);
    chk("abort_mem_addr", bus.mem_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    chk("abort_no_resp", 32'(last_resp), 32'(r));
    do_txn(0, 2'b00, 1, 32'h1, 0, 32'h000000FF, 0, 0, a);
    chk("post_reset_latency", 32'(last_resp - a), 2);
    chk("post_reset_rdata", last_rdata, 32'hFFFFFFFF);

    for (int i = 0; i < 150 && cyc < N - 100; i++) begin
      do_txn($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom,
             $urandom, $urandom, $urandom_range(0, 6), 0, a);
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
